fetch_mo: RTL and testbench

Next-generation instruction fetch front-end with parametrised address width, buffer depth and multiple outstanding I-cache requests. It drives the program counter, issues pipelined requests to the I-cache, squashes stale responses after any redirect by counting them, and queues instructions with their PC, predicted next PC and exception status for decode. It sits between the branch predictor/exception control and the decode stage.

---
 rtl/fetch_mo_pkg.sv | 11 +
 rtl/fetch_ibuf.sv | 76 +++++++
 rtl/fetch_mo.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_mo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_mo_pkg.sv
// fetch_mo_pkg: constants shared by the fetch front-end.
//   RESET_VECTOR                     PC loaded on reset (truncated to XLEN)
//   EXCEPTION_CODE_WIDTH             width of the exception cause field
//   EXCEPTION_INSTR_ADDR_MISALIGNED  cause code for a misaligned fetch PC
package fetch_mo_pkg;

  localparam logic [63:0] RESET_VECTOR = 64'h0;
  localparam int EXCEPTION_CODE_WIDTH = 4;
  localparam logic [EXCEPTION_CODE_WIDTH-1:0] EXCEPTION_INSTR_ADDR_MISALIGNED = 4'd0;

endpackage

// File: rtl/fetch_ibuf.sv
// fetch_ibuf: synchronous FIFO with flush and occupancy count.
//   clk, reset        clock, synchronous active-high reset
//   flush             drop all entries (wins over push and pop)
//   push, push_data   write port; ignored when full unless a pop frees a slot
//   pop, pop_data     read port; pop_data shows the head, valid when !empty
//   count, empty, full occupancy status
// A written entry becomes visible at pop_data the cycle after the write.
module fetch_ibuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_mo.sv
// fetch_mo: instruction fetch front-end with multiple outstanding I-cache
// requests. Drives the PC, issues pipelined requests, squashes stale
// responses after a redirect by counting them, and queues instructions
// (PC, predicted next PC, exception status) for decode.
//   clk, reset                        clock, synchronous active-high reset
//   trap/mret, *_vector               exception-control redirects
//   br_redirect_valid/_target         branch mispredict redirect
//   wfi                               suppress new requests
//   pred_taken/pred_target            predictor result for the current pc
//   icache_req_*                      request handshake, addr = pc
//   icache_resp_*                     in-order response handshake
//   out_*                             decode handshake and entry fields
//   ibuf_empty                        instruction buffer has no entries
// Optional: FETCH_PERF_CNT_EN adds perf_squash_cnt and perf_stall_cnt.
module fetch_mo
  import fetch_mo_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int IBUF_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            trap,
  input  logic                            mret,
  input  logic [XLEN-1:0]                 trap_vector,
  input  logic [XLEN-1:0]                 mret_vector,
  input  logic                            br_redirect_valid,
  input  logic [XLEN-1:0]                 br_redirect_target,
  input  logic                            wfi,
  input  logic                            pred_taken,
  input  logic [XLEN-1:0]                 pred_target,
  output logic                            icache_req_valid,
  input  logic                            icache_req_ready,
  output logic [XLEN-1:0]                 icache_req_addr,
  input  logic                            icache_resp_valid,
  output logic                            icache_resp_ready,
  input  logic [31:0]                     icache_resp_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_pc,
  output logic [XLEN-1:0]                 out_next_pc,
  output logic [31:0]                     out_instr,
  output logic                            out_exc_valid,
  output logic [EXCEPTION_CODE_WIDTH-1:0] out_ecause,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                     perf_squash_cnt,
  output logic [31:0]                     perf_stall_cnt,
`endif
  output logic                            ibuf_empty
);

  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IAW = $clog2(IBUF_DEPTH) + 1;
  localparam int SW  = IAW + 1;
  localparam int MW  = 2 * XLEN;
  localparam int IW  = 2 * XLEN + 32 + 1 + EXCEPTION_CODE_WIDTH;
  localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            halted_q, halted_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            aligned, credit_ok;
  logic            req_fire, resp_fire, resp_drop, resp_keep, exc_push;
  logic [XLEN-1:0] next_pc;

  logic [MW-1:0]   meta_rd;
  logic [OW-1:0]   meta_count;
  logic            meta_empty, meta_full;
  logic [IW-1:0]   ibuf_wr, ibuf_rd;
  logic [IAW-1:0]  ibuf_count;
  logic            ibuf_full;
  logic            unused_meta;

  always_comb begin
    redirect        = trap || mret || br_redirect_valid;
    redirect_target = br_redirect_target;
    if (trap)      redirect_target = trap_vector;
    else if (mret) redirect_target = mret_vector;
  end

  assign aligned = (pc_q[1:0] == 2'b00);

  // Credits cover both buffered entries and in-flight requests, so every
  // response that comes back is guaranteed a buffer slot.
  assign credit_ok = (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                     ((SW'(ibuf_count) + SW'(outstanding_q)) < SW'(IBUF_DEPTH));

  assign icache_req_valid  = !reset && !redirect && !wfi && aligned && !halted_q && credit_ok;
  assign icache_req_addr   = pc_q;
  assign icache_resp_ready = 1'b1;

  assign req_fire  = icache_req_valid && icache_req_ready;
  assign resp_fire = icache_resp_valid;
  assign resp_drop = resp_fire && (drop_cnt_q != '0);
  assign resp_keep = resp_fire && (drop_cnt_q == '0) && !redirect;
  assign next_pc   = pred_taken ? pred_target : pc_q + XLEN'(4);

  // Misaligned pc reports once all older traffic has drained.
  assign exc_push = !reset && !redirect && !aligned && !halted_q &&
                    (outstanding_q == '0) && (drop_cnt_q == '0) && !ibuf_full;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_fire);
    drop_cnt_d    = drop_cnt_q;
    halted_d      = halted_q;
    if (redirect) begin
      pc_d       = redirect_target;
      drop_cnt_d = outstanding_q - OW'(resp_fire);
      halted_d   = 1'b0;
    end else begin
      if (req_fire)  pc_d       = next_pc;
      if (resp_drop) drop_cnt_d = drop_cnt_q - OW'(1);
      if (exc_push)  halted_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RST_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halted_q      <= halted_d;
    end
  end

  fetch_ibuf #(.WIDTH(MW), .DEPTH(MAX_OUTSTANDING)) u_meta (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (req_fire),
    .push_data ({pc_q, next_pc}),
    .pop       (resp_keep),
    .pop_data  (meta_rd),
    .count     (meta_count),
    .empty     (meta_empty),
    .full      (meta_full)
  );

  assign unused_meta = ^{meta_count, meta_empty, meta_full};

  always_comb begin
    if (exc_push)
      ibuf_wr = {pc_q, pc_q, 32'h0, 1'b1, EXCEPTION_INSTR_ADDR_MISALIGNED};
    else
      ibuf_wr = {meta_rd, icache_resp_data, 1'b0, {EXCEPTION_CODE_WIDTH{1'b0}}};
  end

  fetch_ibuf #(.WIDTH(IW), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_keep || exc_push),
    .push_data (ibuf_wr),
    .pop       (out_ready),
    .pop_data  (ibuf_rd),
    .count     (ibuf_count),
    .empty     (ibuf_empty),
    .full      (ibuf_full)
  );

  assign out_valid = !ibuf_empty;
  assign {out_pc, out_next_pc, out_instr, out_exc_valid, out_ecause} = ibuf_rd;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] squash_cnt_q, squash_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    squash_cnt_d = squash_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    // A response arriving with a redirect is discarded too.
    if (resp_fire && (drop_cnt_q != '0 || redirect) && squash_cnt_q != '1)
      squash_cnt_d = squash_cnt_q + 32'd1;
    if (!wfi && !credit_ok && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      squash_cnt_q <= squash_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign perf_squash_cnt = squash_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_mo.sv
module tb_fetch_mo;
  import fetch_mo_pkg::*;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap, mret, br_redirect_valid, wfi;
  logic [31:0] trap_vector, mret_vector, br_redirect_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        icache_req_valid, icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid, icache_resp_ready;
  logic [31:0] icache_resp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_next_pc, out_instr;
  logic        out_exc_valid;
  logic [EXCEPTION_CODE_WIDTH-1:0] out_ecause;
  logic        ibuf_empty;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_squash_cnt, perf_stall_cnt;
`endif

  fetch_mo #(.XLEN(32), .IBUF_DEPTH(8), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .trap(trap), .mret(mret),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .br_redirect_valid(br_redirect_valid), .br_redirect_target(br_redirect_target),
    .wfi(wfi), .pred_taken(pred_taken), .pred_target(pred_target),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_resp_valid(icache_resp_valid),
    .icache_resp_ready(icache_resp_ready), .icache_resp_data(icache_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_next_pc(out_next_pc), .out_instr(out_instr), .out_exc_valid(out_exc_valid),
    .out_ecause(out_ecause),
`ifdef FETCH_PERF_CNT_EN
    .perf_squash_cnt(perf_squash_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .ibuf_empty(ibuf_empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int rdy; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] nxt; logic [31:0] instr;
                   logic exc; logic [EXCEPTION_CODE_WIDTH-1:0] cause; } ent_t;

  pend_t pend[$];
  ent_t  obs[$];
  int    cyc = 0;
  int    lat = 1;
  int    req_cnt = 0;
  int    errors = 0;
  int    checks = 0;
  logic  pred_en = 1'b0;

  // I-cache and predictor model: drives at the falling edge, records the
  // handshakes that will complete at the following rising edge.
  always begin
    @(negedge clk);
    pred_taken  = pred_en && (icache_req_addr == 32'h10);
    pred_target = 32'h40;
    if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      icache_resp_valid = 1'b1;
      icache_resp_data  = pend[0].addr ^ K;
    end else begin
      icache_resp_valid = 1'b0;
      icache_resp_data  = 32'h0;
    end
    #3;
    if (reset) begin
      pend.delete();
    end else begin
      if (icache_resp_valid && icache_resp_ready) pend.delete(0);
      if (icache_req_valid && icache_req_ready) begin
        pend.push_back('{icache_req_addr, cyc + lat});
        req_cnt++;
      end
      if (out_valid && out_ready)
        obs.push_back('{out_pc, out_next_pc, out_instr, out_exc_valid, out_ecause});
    end
    cyc++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; trap = 1'b0; mret = 1'b0; br_redirect_valid = 1'b0; wfi = 1'b0;
    pred_en = 1'b0; out_ready = 1'b1; icache_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs.delete();
    req_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", icache_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (ibuf_empty !== 1'b1) begin errors++; $display("FAIL reset_ibuf_empty: got %b expected 1", ibuf_empty); end
    checks++; if (icache_resp_ready !== 1'b1) begin errors++; $display("FAIL reset_resp_ready: got %b expected 1", icache_resp_ready); end
    checks++; if (icache_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 00000000", icache_req_addr); end
    @(negedge clk);
    reset = 1'b0; obs.delete(); req_cnt = 0;
    #4;
    checks++; if (icache_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", icache_req_valid); end
    checks++; if (icache_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 00000000", icache_req_addr); end
  endtask

  task automatic test_in_order();
    lat = 1;
    do_reset();
    @(negedge clk); #4;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got out_valid=%b expected 0", out_valid); end
    @(negedge clk); #4;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL resp_to_out: got valid=%b pc=%h expected 1/00000000", out_valid, out_pc); end
    repeat (10) @(negedge clk);
    #4;
    checks++; if (obs.size() < 3) begin errors++; $display("FAIL seq_count: got %0d expected >=3", obs.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] epc;
      epc = 32'(i * 4);
      checks++; if (obs[i].pc !== epc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, obs[i].pc, epc); end
      checks++; if (obs[i].nxt !== epc + 32'd4) begin errors++; $display("FAIL seq_next[%0d]: got %h expected %h", i, obs[i].nxt, epc + 32'd4); end
      checks++; if (obs[i].instr !== (epc ^ K)) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, obs[i].instr, epc ^ K); end
      checks++; if (obs[i].exc !== 1'b0) begin errors++; $display("FAIL seq_exc[%0d]: got %b expected 0", i, obs[i].exc); end
    end
  endtask

  task automatic test_redirect_drop();
    lat = 3;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #4;
      if (pend.size() == 2) break;
    end
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL inflight: got %0d expected 2", pend.size()); end
    @(negedge clk);
    br_redirect_valid = 1'b1; br_redirect_target = 32'h100;
    @(negedge clk);
    br_redirect_valid = 1'b0;
    repeat (15) @(negedge clk);
    #4;
    checks++; if (obs.size() < 2) begin errors++; $display("FAIL drop_count: got %0d expected >=2", obs.size()); end
    checks++; if (obs[0].pc !== 32'h100) begin errors++; $display("FAIL drop_pc0: got %h expected 00000100", obs[0].pc); end
    checks++; if (obs[0].instr !== (32'h100 ^ K)) begin errors++; $display("FAIL drop_instr0: got %h expected %h", obs[0].instr, 32'h100 ^ K); end
    checks++; if (obs[1].pc !== 32'h104) begin errors++; $display("FAIL drop_pc1: got %h expected 00000104", obs[1].pc); end
  endtask

  task automatic test_backpressure();
    lat = 1;
    do_reset();
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    #4;
    checks++; if (req_cnt != 8) begin errors++; $display("FAIL bp_req_cnt: got %0d expected 8", req_cnt); end
    checks++; if (obs.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d expected 0", obs.size()); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h expected 1/00000000", out_valid, out_pc); end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    #4;
    checks++; if (obs.size() < 10) begin errors++; $display("FAIL bp_release_count: got %0d expected >=10", obs.size()); end
    for (int i = 0; i < 10; i++) begin
      logic [31:0] epc;
      epc = 32'(i * 4);
      checks++; if (obs[i].pc !== epc) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, obs[i].pc, epc); end
      checks++; if (obs[i].instr !== (epc ^ K)) begin errors++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, obs[i].instr, epc ^ K); end
    end
  endtask

  task automatic test_pred_taken();
    lat = 1;
    do_reset();
    pred_en = 1'b1;
    repeat (15) @(negedge clk);
    #4;
    checks++; if (obs.size() < 6) begin errors++; $display("FAIL pred_count: got %0d expected >=6", obs.size()); end
    checks++; if (obs[3].nxt !== 32'h10) begin errors++; $display("FAIL pred_next3: got %h expected 00000010", obs[3].nxt); end
    checks++; if (obs[4].pc !== 32'h10) begin errors++; $display("FAIL pred_pc4: got %h expected 00000010", obs[4].pc); end
    checks++; if (obs[4].nxt !== 32'h40) begin errors++; $display("FAIL pred_next4: got %h expected 00000040", obs[4].nxt); end
    checks++; if (obs[5].pc !== 32'h40) begin errors++; $display("FAIL pred_pc5: got %h expected 00000040", obs[5].pc); end
    checks++; if (obs[5].nxt !== 32'h44) begin errors++; $display("FAIL pred_next5: got %h expected 00000044", obs[5].nxt); end
    @(negedge clk);
    pred_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    lat = 1;
    do_reset();
    repeat (4) @(negedge clk);
    trap = 1'b1; trap_vector = 32'h200;
    mret = 1'b1; mret_vector = 32'h280;
    br_redirect_valid = 1'b1; br_redirect_target = 32'h300;
    #4;
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %b expected 0", icache_req_valid); end
    @(negedge clk);
    trap = 1'b0;
    #4;
    checks++; if (icache_req_addr !== 32'h200) begin errors++; $display("FAIL trap_priority: got %h expected 00000200", icache_req_addr); end
    checks++; if (ibuf_empty !== 1'b1) begin errors++; $display("FAIL redir_flush: got %b expected 1", ibuf_empty); end
    @(negedge clk);
    mret = 1'b0;
    #4;
    checks++; if (icache_req_addr !== 32'h280) begin errors++; $display("FAIL mret_priority: got %h expected 00000280", icache_req_addr); end
    @(negedge clk);
    br_redirect_target = 32'h380;
    #4;
    checks++; if (icache_req_addr !== 32'h300) begin errors++; $display("FAIL br_target: got %h expected 00000300", icache_req_addr); end
    @(negedge clk);
    br_redirect_valid = 1'b0;
    obs.delete();
    #4;
    checks++; if (icache_req_addr !== 32'h380) begin errors++; $display("FAIL later_wins: got %h expected 00000380", icache_req_addr); end
    repeat (8) @(negedge clk);
    #4;
    checks++; if (obs.size() < 2 || obs[0].pc !== 32'h380 || obs[1].pc !== 32'h384) begin
      errors++; $display("FAIL b2b_delivery: got n=%0d pc0=%h pc1=%h expected 00000380/00000384", obs.size(), obs[0].pc, obs[1].pc);
    end
  endtask

  task automatic test_misaligned();
    int base;
    lat = 1;
    do_reset();
    repeat (4) @(negedge clk);
    mret = 1'b1; mret_vector = 32'h102;
    @(negedge clk);
    mret = 1'b0;
    obs.delete();
    base = req_cnt;
    repeat (12) @(negedge clk);
    #4;
    checks++; if (req_cnt != base) begin errors++; $display("FAIL mis_no_req: got %0d requests expected 0", req_cnt - base); end
    checks++; if (obs.size() != 1) begin errors++; $display("FAIL mis_count: got %0d expected 1", obs.size()); end
    checks++; if (obs[0].pc !== 32'h102) begin errors++; $display("FAIL mis_pc: got %h expected 00000102", obs[0].pc); end
    checks++; if (obs[0].nxt !== 32'h102) begin errors++; $display("FAIL mis_next: got %h expected 00000102", obs[0].nxt); end
    checks++; if (obs[0].instr !== 32'h0) begin errors++; $display("FAIL mis_instr: got %h expected 00000000", obs[0].instr); end
    checks++; if (obs[0].exc !== 1'b1) begin errors++; $display("FAIL mis_exc: got %b expected 1", obs[0].exc); end
    checks++; if (obs[0].cause !== EXCEPTION_INSTR_ADDR_MISALIGNED) begin errors++; $display("FAIL mis_cause: got %h expected %h", obs[0].cause, EXCEPTION_INSTR_ADDR_MISALIGNED); end
    @(negedge clk);
    br_redirect_valid = 1'b1; br_redirect_target = 32'h80;
    @(negedge clk);
    br_redirect_valid = 1'b0;
    obs.delete();
    repeat (8) @(negedge clk);
    #4;
    checks++; if (obs.size() < 1 || obs[0].pc !== 32'h80 || obs[0].exc !== 1'b0) begin
      errors++; $display("FAIL halt_clear: got n=%0d pc=%h exc=%b expected 00000080/0", obs.size(), obs[0].pc, obs[0].exc);
    end
  endtask

  task automatic test_wfi();
    lat = 1;
    do_reset();
    wfi = 1'b1;
    repeat (6) @(negedge clk);
    #4;
    checks++; if (req_cnt != 0) begin errors++; $display("FAIL wfi_req_cnt: got %0d expected 0", req_cnt); end
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL wfi_req_valid: got %b expected 0", icache_req_valid); end
    @(negedge clk);
    wfi = 1'b0;
    #4;
    checks++; if (icache_req_valid !== 1'b1) begin errors++; $display("FAIL wfi_release: got %b expected 1", icache_req_valid); end
  endtask

  initial begin
    reset = 1'b1; trap = 1'b0; mret = 1'b0; br_redirect_valid = 1'b0; wfi = 1'b0;
    trap_vector = '0; mret_vector = '0; br_redirect_target = '0;
    out_ready = 1'b1; icache_req_ready = 1'b1;
    pred_taken = 1'b0; pred_target = '0; icache_resp_valid = 1'b0; icache_resp_data = '0;
    test_reset();
    test_in_order();
    test_redirect_drop();
    test_backpressure();
    test_pred_taken();
    test_back_to_back();
    test_misaligned();
    test_wfi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
